execute_muldiv: RTL and testbench

Multi-cycle execute unit for the RV64 M extension, parametrised in data width and multiplier latency. It sits in the execute stage beside the single-cycle ALU. The stage steers MUL/DIV/REM-class instructions here and stalls on the handshake until the result returns. It replaces the single-cycle, always-complete model with a valid/ready handshake, an iterative divider, a fixed-latency multiplier, word (*W) variants, and pipeline flush.

---
 rtl/execute_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_execute_muldiv.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Multi-cycle RV64 M-extension execute unit: fixed-latency multiplier, radix-2
// restoring divider, *W variants, valid/ready handshake and pipeline flush.
module execute_muldiv #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // MUL   | multiply latency countdown
  // DIV   | one quotient bit per cycle
  // DONE  | result held until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CMAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [XLEN-1:0] LOW_ONES = XLEN'(32'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MIN_NEG  = XLEN'(1) << (XLEN - 1);
  localparam logic [XLEN-1:0] MIN_WORD = ~LOW_ONES | (XLEN'(1) << 31);

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x, input logic sgn);
    logic [XLEN-1:0] r;
    r = x & LOW_ONES;
    if (sgn && x[31]) r = r | ~LOW_ONES;
    return r;
  endfunction

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic            word_q;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] rem_q;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // request decode, evaluated on the raw inputs at accept
  logic            word_en, div_signed, word_op, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_op, b_op, a_mag, b_mag, q_init, special_res;

  always_comb begin
    word_en    = (XLEN == 64) && in_word;
    div_signed = in_funct3[2] & ~in_funct3[0];
    word_op    = word_en & (in_funct3[2] | (in_funct3[1:0] == 2'b00));
    a_op       = word_en ? sext32(in_a, div_signed) : in_a;
    b_op       = word_en ? sext32(in_b, div_signed) : in_b;
    a_neg      = div_signed & a_op[XLEN-1];
    b_neg      = div_signed & b_op[XLEN-1];
    a_mag      = a_neg ? -a_op : a_op;
    b_mag      = b_neg ? -b_op : b_op;
    // left-align the dividend so word ops finish after 32 shifts
    q_init     = word_en ? (a_mag << (XLEN - 32)) : a_mag;
    div_zero   = (b_op == '0);
    ovf        = div_signed & (a_op == (word_en ? MIN_WORD : MIN_NEG)) & (b_op == '1);
    special_res = '0;
    if (div_zero) begin
      if (in_funct3[1]) special_res = word_en ? sext32(in_a, 1'b1) : in_a;
      else              special_res = '1;
    end else if (ovf) begin
      special_res = in_funct3[1] ? '0 : a_op;
    end
  end

  logic [XLEN:0]   rem_sh, diff;
  logic            fits;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, div_res;

  always_comb begin
    rem_sh  = {rem_q, op_a[XLEN-1]};
    diff    = rem_sh - {1'b0, op_b};
    fits    = ~diff[XLEN];
    rem_nx  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {op_a[XLEN-2:0], fits};
    q_fix   = q_neg ? -quo_nx : quo_nx;
    r_fix   = r_neg ? -rem_nx : rem_nx;
    div_res = f3_q[1] ? r_fix : q_fix;
    if (word_q) div_res = sext32(div_res, 1'b1);
  end

  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]   mul_res;

  // sign-extending to 2*XLEN makes the modular product exact for every signedness mix
  always_comb begin
    a_sgn   = (f3_q[1:0] != 2'b11);
    b_sgn   = ~f3_q[1];
    a_ext   = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
    b_ext   = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
    prod    = a_ext * b_ext;
    if (f3_q[1:0] == 2'b00)
      mul_res = word_q ? sext32(prod[XLEN-1:0], 1'b1) : prod[XLEN-1:0];
    else
      mul_res = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      word_q     <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      rem_q      <= '0;
      out_result <= '0;
      out_rd     <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          out_rd <= in_rd;
          f3_q   <= in_funct3;
          word_q <= word_op;
          if (!in_funct3[2]) begin
            state <= S_MUL;
            cnt   <= CW'(MUL_CYCLES - 1);
            op_a  <= in_a;
            op_b  <= in_b;
          end else if (div_zero || ovf) begin
            state      <= S_DONE;
            out_result <= special_res;
          end else begin
            state <= S_DIV;
            cnt   <= word_en ? CW'(31) : CW'(XLEN - 1);
            op_a  <= q_init;
            op_b  <= b_mag;
            rem_q <= '0;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            state      <= S_DONE;
            out_result <= mul_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          op_a  <= quo_nx;
          rem_q <= rem_nx;
          if (cnt == '0) begin
            state      <= S_DONE;
            out_result <= div_res;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized and directed bench for execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;
  localparam int XLEN       = 64;
  localparam int MUL_CYCLES = 3;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_funct3 = '0;
  logic            in_word = 1'b0;
  logic [63:0]     in_a = '0;
  logic [63:0]     in_b = '0;
  logic [4:0]      in_rd = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [63:0]     out_result;
  logic [4:0]      out_rd;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  execute_muldiv #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_word(in_word), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    longint sa, sb;
    longint unsigned ua, ub;
    int wa, wb;
    int unsigned uwa, uwb;
    logic [31:0] r32;
    logic wovf, dovf;
    sa = a; sb = b; ua = a; ub = b;
    wa = a[31:0]; wb = b[31:0]; uwa = a[31:0]; uwb = b[31:0];
    wovf = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    dovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    case (f3)
      3'd0: begin
        if (w) begin r32 = a[31:0] * b[31:0]; return sx(r32); end
        return a * b;
      end
      3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
      3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
      3'd3: begin pa = {64'd0, a};       pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
      3'd4: begin
        if (w) begin
          if (wb == 0) return '1;
          if (wovf) return sx(a[31:0]);
          r32 = wa / wb; return sx(r32);
        end
        if (sb == 0) return '1;
        if (dovf) return a;
        return sa / sb;
      end
      3'd5: begin
        if (w) begin
          if (uwb == 0) return '1;
          r32 = uwa / uwb; return sx(r32);
        end
        if (ub == 0) return '1;
        return ua / ub;
      end
      3'd6: begin
        if (w) begin
          if (wb == 0) return sx(a[31:0]);
          if (wovf) return '0;
          r32 = wa % wb; return sx(r32);
        end
        if (sb == 0) return a;
        if (dovf) return '0;
        return sa % sb;
      end
      default: begin
        if (w) begin
          if (uwb == 0) return sx(a[31:0]);
          r32 = uwa % uwb; return sx(r32);
        end
        if (ub == 0) return a;
        return ua % ub;
      end
    endcase
  endfunction

  // edges from the accept edge (inclusive) to the edge that raises out_valid
  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic bz, ov;
    if (!f3[2]) return MUL_CYCLES + 1;
    bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ov = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                      : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (bz || ov) return 1;
    return (w ? 32 : 64) + 1;
  endfunction

  task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input string tag);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; in_funct3 = f3; in_word = w; in_a = a; in_b = b; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_result(input logic [2:0] f3, input logic w, input logic [63:0] a,
                             input logic [63:0] b, input logic [4:0] rd, input string tag);
    int lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 64'(lat), 64'(ref_lat(f3, w, a, b)));
    check({tag, "_res"}, out_result, ref_model(f3, w, a, b));
    check({tag, "_rd"}, 64'(out_rd), 64'(rd));
  endtask

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input string tag);
    start_op(f3, w, a, b, rd, tag);
    wait_result(f3, w, a, b, rd, tag);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_pulse"}, out_valid, 0);
      check({tag, "_idle"}, in_ready, 1);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [2:0]  rf;
    logic        rw;

    #23;
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_rd", 64'(out_rd), 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 0, 64'd7, -64'sd3, 5'd3, "mul");
    run_op(3'd3, 0, '1, '1, 5'd4, "mulhu");
    run_op(3'd2, 0, '1, 64'd2, 5'd6, "mulhsu");
    run_op(3'd1, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7, "mulh");
    run_op(3'd0, 1, 64'hDEAD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 5'd8, "mulw");
    run_op(3'd4, 0, -64'sd20, 64'd3, 5'd9, "div");
    run_op(3'd6, 0, -64'sd20, 64'd3, 5'd10, "rem");
    run_op(3'd5, 1, 64'h1_8000_0000, 64'd1, 5'd11, "divuw");
    run_op(3'd5, 0, 64'd123, 64'd0, 5'd12, "divu0");
    run_op(3'd6, 0, 64'd5, 64'd0, 5'd13, "rem0");
    run_op(3'd4, 0, 64'h8000_0000_0000_0000, '1, 5'd14, "divovf");
    run_op(3'd6, 1, 64'h1234_5678_8000_0000, 64'h0000_0001_FFFF_FFFF, 5'd15, "remwovf");
    run_op(3'd7, 1, 64'h0000_0000_9000_0000, 64'd0, 5'd16, "remuw0");

    // backpressure in DONE
    out_ready = 1'b0;
    start_op(3'd1, 0, 64'h1234_5678_9ABC_DEF0, -64'sd77, 5'd17, "bp");
    wait_result(3'd1, 0, 64'h1234_5678_9ABC_DEF0, -64'sd77, 5'd17, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_hold", out_result, ref_model(3'd1, 0, 64'h1234_5678_9ABC_DEF0, -64'sd77));
      check("bp_rd", 64'(out_rd), 64'd17);
      check("bp_inready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    run_op(3'd5, 0, 64'd1000, 64'd7, 5'd18, "bp_next");

    // flush mid-divide with a competing request
    start_op(3'd4, 0, -64'sd1000, 64'd9, 5'd19, "fl");
    repeat (19) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'd0; in_word = 1'b0;
    in_a = 64'd3; in_b = 64'd4; in_rd = 5'd20;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_ready", in_ready, 1);
    check("fl_valid", out_valid, 0);
    check("fl_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("fl_quiet", out_valid, 0);
    end
    run_op(3'd6, 0, -64'sd1000, 64'd9, 5'd21, "fl_next");

    // asynchronous reset mid-divide
    start_op(3'd5, 0, '1, 64'd3, 5'd22, "ar");
    repeat (10) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_result", out_result, 0);
    check("ar_rd", 64'(out_rd), 0);
    check("ar_busy", busy, 0);
    check("ar_ready", in_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd4, 1, 64'h0000_0000_FFFF_FF9C, 64'h0000_0000_0000_0007, 5'd23, "ar_next");

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = 64'd0;
        1: begin rb = '1; ra = rw ? {ra[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000; end
        2: rb = 64'($urandom_range(1, 20));
        3: rb = {32'($urandom), 32'($urandom_range(0, 2))};
        default: ;
      endcase
      run_op(rf, rw, ra, rb, 5'($urandom), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
